// File: rtl/shift_arbiter_pkg.sv
// Shared types for the two-port shift arbiter.
// Op codes, FSM encoding, widths and a bit-reverse helper.
package shift_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      OP_SRL = 2'b00,
      OP_SRA = 2'b01,
      OP_SLL = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PASS2 = 2'b01,
      RESP  = 2'b10
   } state_e;

   function automatic logic [WIDTH-1:0] rev(
      input logic [WIDTH-1:0] v
   );
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++)
         r[i] = v[WIDTH-1-i];
      return r;
   endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the arbiter.
// master = requesters plus response consumer, slave = shift_arbiter.
interface shift_arbiter_if;

   logic                                 req0_valid;
   logic                                 req0_ready;
   shift_pkg::op_e                       req0_op;
   logic [shift_pkg::WIDTH-1:0]          req0_a;
   logic [shift_pkg::SHAMT_W-1:0]        req0_shamt;

   logic                                 req1_valid;
   logic                                 req1_ready;
   shift_pkg::op_e                       req1_op;
   logic [shift_pkg::WIDTH-1:0]          req1_a;
   logic [shift_pkg::SHAMT_W-1:0]        req1_shamt;

   logic                                 rsp_valid;
   logic                                 rsp_ready;
   logic [shift_pkg::WIDTH-1:0]          rsp_data;
   logic                                 rsp_id;

   modport master (
      output req0_valid, req0_op, req0_a, req0_shamt,
      output req1_valid, req1_op, req1_a, req1_shamt,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_shamt,
      input  req1_valid, req1_op, req1_a, req1_shamt,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/shift_arbiter_barrel.sv
// 32-bit right-only logarithmic barrel shifter.
// make_up is the fill bit shifted in from the top.
module barrelshifter_32
   import shift_pkg::*;
(
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] amt,
   input  logic               make_up,
   output logic [WIDTH-1:0]   dout
);

   logic [WIDTH-1:0] stg [0:SHAMT_W];

   assign stg[0] = din;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int S = 1 << k;
      assign stg[k+1] = amt[k]
         ? {{S{make_up}}, stg[k][WIDTH-1:S]}
         : stg[k];
   end

   assign dout = stg[SHAMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter sharing one right barrel shifter.
// Define SHIFT_ROR_EN to enable two-pass ROR; otherwise op 11 acts as SRL.
module shift_arbiter
   import shift_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   shift_arbiter_if.slave bus
);

   state_e               state;
   logic                 last_grant;
   logic                 acc_en;
   logic                 g0;
   logic                 g1;
   logic                 accept;
   logic                 sel;
   op_e                  op_s;
   logic [WIDTH-1:0]     a_s;
   logic [SHAMT_W-1:0]   sh_s;
   logic [WIDTH-1:0]     sh_in;
   logic [SHAMT_W-1:0]   sh_amt;
   logic                 sh_mu;
   logic [WIDTH-1:0]     sh_out;
   logic [WIDTH-1:0]     result;
   logic                 rsp_valid_q;
   logic [WIDTH-1:0]     rsp_data_q;
   logic                 rsp_id_q;
`ifdef SHIFT_ROR_EN
   logic [WIDTH-1:0]     part;
   logic [WIDTH-1:0]     a_q;
   logic [SHAMT_W-1:0]   shamt_q;
`endif

   assign acc_en = (state == IDLE) |
                   ((state == RESP) & bus.rsp_ready);

   // a tie goes to the port that did not win last time
   assign g0 = bus.req0_valid & (~bus.req1_valid | last_grant);
   assign g1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);

   assign bus.req0_ready = acc_en & g0 & ~rst;
   assign bus.req1_ready = acc_en & g1 & ~rst;

   assign accept = acc_en & (g0 | g1) & ~rst;
   assign sel    = g1;

   assign op_s = sel ? bus.req1_op    : bus.req0_op;
   assign a_s  = sel ? bus.req1_a     : bus.req0_a;
   assign sh_s = sel ? bus.req1_shamt : bus.req0_shamt;

   // shifter operand mux; SLL rides the right shifter via bit reversal
   always_comb begin
      sh_in  = a_s;
      sh_amt = sh_s;
      sh_mu  = 1'b0;
      case (op_s)
         OP_SRA:  sh_mu = a_s[WIDTH-1];
         OP_SLL:  sh_in = rev(a_s);
         default: ;
      endcase
`ifdef SHIFT_ROR_EN
      if (state == PASS2) begin
         sh_in  = rev(a_q);
         sh_amt = SHAMT_W'(0) - shamt_q;
         sh_mu  = 1'b0;
      end
`endif
   end

   barrelshifter_32 u_shift (
      .din     (sh_in),
      .amt     (sh_amt),
      .make_up (sh_mu),
      .dout    (sh_out)
   );

   assign result = (op_s == OP_SLL) ? rev(sh_out) : sh_out;

   // FSM, round-robin pointer and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
`ifdef SHIFT_ROR_EN
         part        <= '0;
         a_q         <= '0;
         shamt_q     <= '0;
`endif
      end else begin
         case (state)
`ifdef SHIFT_ROR_EN
            PASS2: begin
               rsp_data_q  <= part | rev(sh_out);
               rsp_valid_q <= 1'b1;
               state       <= RESP;
            end
`endif
            default: begin
               if (accept) begin
                  last_grant <= sel;
                  rsp_id_q   <= sel;
`ifdef SHIFT_ROR_EN
                  if (op_s == OP_ROR) begin
                     part        <= sh_out;
                     a_q         <= a_s;
                     shamt_q     <= sh_s;
                     rsp_valid_q <= 1'b0;
                     state       <= PASS2;
                  end else
`endif
                  begin
                     rsp_data_q  <= result;
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end
               end else if ((state == RESP) & bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_shift_arbiter;
   import shift_pkg::*;

`ifdef SHIFT_ROR_EN
   localparam bit ROR_ON = 1'b1;
`else
   localparam bit ROR_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   shift_arbiter_if bus ();

   shift_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      op_e         op;
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act,
                       input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input op_e op,
      input logic [31:0] a, input int s);
      case (op)
         OP_SRL: return a >> s;
         OP_SRA: return 32'($signed(a) >>> s);
         OP_SLL: return a << s;
         default: begin
            if (!ROR_ON) return a >> s;
            if (s == 0)  return a;
            return (a >> s) | (a << (32 - s));
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic v, input op_e op,
                        input logic [31:0] a, input logic [4:0] s);
      if (p == 0) begin
         bus.req0_valid = v; bus.req0_op = op;
         bus.req0_a = a;     bus.req0_shamt = s;
      end else begin
         bus.req1_valid = v; bus.req1_op = op;
         bus.req1_a = a;     bus.req1_shamt = s;
      end
   endtask

   task automatic run_vec(input vec_t v);
      bit lat2;
      lat2 = ROR_ON && (v.op == OP_ROR);
      drive(v.port, 1'b1, v.op, v.a, v.shamt);
      bus.rsp_ready = 1'b1;
      #1;
      chk1("vec_ready", v.port == 0 ? bus.req0_ready
                                    : bus.req1_ready, 1'b1);
      tick();
      drive(v.port, 1'b0, OP_SRL, 32'h0, 5'd0);
      if (lat2) begin
         chk1("vec_pass2_valid", bus.rsp_valid, 1'b0);
         tick();
      end
      chk1("vec_rsp_valid", bus.rsp_valid, 1'b1);
      chk("vec_rsp_data", bus.rsp_data, v.exp);
      chk1("vec_rsp_id", bus.rsp_id, v.port[0]);
   endtask

   vec_t tbl[9];

   bit          v0, v1, rr, e0, e1;
   op_e         o0, o1;
   logic [31:0] a0, a1;
   logic [4:0]  s0, s1;
   bit          m_p2, m_valid, m_last, m_id;
   logic [31:0] m_data, m_stash;

   initial begin
      tbl[0] = '{0, OP_SRL, 32'hF000_0000, 5'd4,  32'h0F00_0000};
      tbl[1] = '{1, OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
      tbl[2] = '{1, OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
      tbl[3] = '{0, OP_SRA, 32'h7000_000F, 5'd4,  32'h0700_0000};
      tbl[4] = '{0, OP_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678};
      tbl[5] = '{1, OP_SRA, 32'h8000_0001, 5'd0,  32'h8000_0001};
      tbl[6] = '{0, OP_ROR, 32'h0000_00F1, 5'd4,
                 ROR_ON ? 32'h1000_000F : 32'h0000_000F};
      tbl[7] = '{1, OP_ROR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
      tbl[8] = '{1, OP_ROR, 32'h8000_0001, 5'd1,
                 ROR_ON ? 32'hC000_0000 : 32'h4000_0000};

      // reset: readies blocked even with both requests present
      drive(0, 1'b1, OP_SRL, 32'hAAAA_0000, 5'd0);
      drive(1, 1'b1, OP_SRL, 32'h5555_0001, 5'd0);
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      chk1("rst_ready0", bus.req0_ready, 1'b0);
      chk1("rst_ready1", bus.req1_ready, 1'b0);
      chk1("rst_valid", bus.rsp_valid, 1'b0);
      chk("rst_data", bus.rsp_data, 32'h0);
      chk1("rst_id", bus.rsp_id, 1'b0);

      // alternation: both valid, grants 0,1,0,1
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk1("alt_ready0", bus.req0_ready, k % 2 == 0);
         chk1("alt_ready1", bus.req1_ready, k % 2 == 1);
         tick();
         chk1("alt_valid", bus.rsp_valid, 1'b1);
         chk1("alt_id", bus.rsp_id, k % 2 == 1);
         chk("alt_data", bus.rsp_data,
             k % 2 == 0 ? 32'hAAAA_0000 : 32'h5555_0001);
      end

      // stall: nothing accepted, response held
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk1("stall_ready0", bus.req0_ready, 1'b0);
         chk1("stall_ready1", bus.req1_ready, 1'b0);
         chk1("stall_valid", bus.rsp_valid, 1'b1);
         chk("stall_data", bus.rsp_data, 32'h5555_0001);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk1("release_ready0", bus.req0_ready, 1'b1);
      chk1("release_ready1", bus.req1_ready, 1'b0);
      tick();
      drive(0, 1'b0, OP_SRL, 32'h0, 5'd0);
      drive(1, 1'b0, OP_SRL, 32'h0, 5'd0);
      chk1("release_id", bus.rsp_id, 1'b0);
      chk("release_data", bus.rsp_data, 32'hAAAA_0000);
      tick();
      chk1("drain_valid", bus.rsp_valid, 1'b0);

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);
      tick();

      // ROR second pass: readies low, result two cycles after accept
      if (ROR_ON) begin
         drive(0, 1'b1, OP_ROR, 32'h0000_00F1, 5'd4);
         tick();
         drive(0, 1'b1, OP_SRL, 32'h1, 5'd0);
         drive(1, 1'b1, OP_SRL, 32'h2, 5'd0);
         #1;
         chk1("p2_ready0", bus.req0_ready, 1'b0);
         chk1("p2_ready1", bus.req1_ready, 1'b0);
         chk1("p2_valid", bus.rsp_valid, 1'b0);
         drive(0, 1'b0, OP_SRL, 32'h0, 5'd0);
         drive(1, 1'b0, OP_SRL, 32'h0, 5'd0);
         tick();
         chk1("ror_valid", bus.rsp_valid, 1'b1);
         chk("ror_data", bus.rsp_data, 32'h1000_000F);
         chk1("ror_id", bus.rsp_id, 1'b0);
         tick();
      end

      // reset while an operation is in flight
      bus.rsp_ready = 1'b0;
      drive(0, 1'b1, OP_ROR, 32'h0000_00F1, 5'd4);
      tick();
      drive(0, 1'b0, OP_SRL, 32'h0, 5'd0);
      if (ROR_ON) chk1("mid_p2_valid", bus.rsp_valid, 1'b0);
      rst = 1'b1;
      drive(0, 1'b1, OP_SRL, 32'h1, 5'd0);
      drive(1, 1'b1, OP_SRL, 32'h2, 5'd0);
      tick();
      chk1("mid_rst_valid", bus.rsp_valid, 1'b0);
      chk("mid_rst_data", bus.rsp_data, 32'h0);
      chk1("mid_rst_id", bus.rsp_id, 1'b0);
      chk1("mid_rst_ready0", bus.req0_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk1("post_rst_ready0", bus.req0_ready, 1'b1);
      chk1("post_rst_ready1", bus.req1_ready, 1'b0);
      drive(0, 1'b0, OP_SRL, 32'h0, 5'd0);
      drive(1, 1'b0, OP_SRL, 32'h0, 5'd0);
      tick();

      // randomized traffic against the model
      v0 = 0; v1 = 0;
      m_p2 = 0; m_valid = 0; m_last = 1; m_id = 0;
      m_data = '0; m_stash = '0;
      o0 = OP_SRL; o1 = OP_SRL;
      a0 = '0; a1 = '0; s0 = '0; s1 = '0;
      for (int c = 0; c < 400; c++) begin
         if (!v0 && $urandom_range(0, 2) != 0) begin
            v0 = 1; o0 = op_e'($urandom_range(0, 3));
            a0 = $urandom; s0 = 5'($urandom_range(0, 31));
         end
         if (!v1 && $urandom_range(0, 2) != 0) begin
            v1 = 1; o1 = op_e'($urandom_range(0, 3));
            a1 = $urandom; s1 = 5'($urandom_range(0, 31));
         end
         rr = ($urandom_range(0, 3) != 0);
         drive(0, v0, o0, a0, s0);
         drive(1, v1, o1, a1, s1);
         bus.rsp_ready = rr;
         #1;
         e0 = !m_p2 && (!m_valid || rr) && v0 && (!v1 || m_last);
         e1 = !m_p2 && (!m_valid || rr) && v1 && (!v0 || !m_last);
         chk1("rnd_ready0", bus.req0_ready, e0);
         chk1("rnd_ready1", bus.req1_ready, e1);
         chk1("rnd_valid", bus.rsp_valid, m_valid);
         if (m_valid) begin
            chk("rnd_data", bus.rsp_data, m_data);
            chk1("rnd_id", bus.rsp_id, m_id);
         end
         tick();
         if (e0 || e1) begin
            m_last = e1;
            m_id   = e1;
            if (e1) m_stash = ref_shift(o1, a1, int'(s1));
            else    m_stash = ref_shift(o0, a0, int'(s0));
            if (ROR_ON && (e1 ? o1 : o0) == OP_ROR) begin
               m_p2 = 1; m_valid = 0;
            end else begin
               m_valid = 1; m_data = m_stash;
            end
            if (e1) v1 = 0;
            else    v0 = 0;
         end else if (m_p2) begin
            m_p2 = 0; m_valid = 1; m_data = m_stash;
         end else if (m_valid && rr) begin
            m_valid = 0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
